// File: rtl/fetch_unit_pkg.sv
// Shared core types for the fetch stage: data width, reset PC, FSM states, queue entry.
package fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    TRAP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus bundle: imem request/response, redirect from execute, decode handshake.
// master = fetch unit side, slave = memory/execute/decode side.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_inst;
  logic            fetch_misalign;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, fetch_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_inst, fetch_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: synchronous FIFO with flush; registered storage, dout shows the head entry.
// Latency: push visible at dout the cycle after; push while full is accepted only with a pop.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// RV32I fetch stage: PC, imem requests, in-order queue to decode; optional FETCH_MISALIGN_TRAP_EN.
// Latency: response -> if_valid next cycle; redirect -> new request next cycle when capacity allows.
// Backpressure: requests issue only while in-flight + queued (minus a pop) < BUF_DEPTH.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int              BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW:0]     inflight;

  logic            redir;
  logic            redir_mis;
  logic            req_fire;
  logic            if_fire;
  logic            rsp_keep;
  logic            flush;

  fq_entry_t       q_din, q_dout;
  logic [CW-1:0]   q_count;
  logic            q_full, q_empty;
  logic [XLEN-1:0] pcf_dout;
  logic [CW-1:0]   pcf_count;
  logic            pcf_full, pcf_empty;
  logic            unused_ok;

  assign redir = bus.redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_mis          = redir && (bus.redirect_pc[1:0] != 2'b00);
  assign flush              = redir || (state_q == TRAP);
  assign bus.fetch_misalign = (state_q == TRAP);
`else
  assign redir_mis          = 1'b0;
  assign flush              = redir;
  assign bus.fetch_misalign = 1'b0;
`endif

  // A same-cycle pop frees a queue slot, which keeps a 1-cycle memory at full rate.
  // The sum can only shrink while a request waits, so a raised request never drops on its own.
  assign if_fire  = bus.if_valid && bus.if_ready;
  assign inflight = {1'b0, outst_q} + {1'b0, q_count} - {{CW{1'b0}}, if_fire};

  assign bus.imem_req_valid = (state_q == FETCH) && !redir && (inflight < (CW+1)'(BUF_DEPTH));
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_keep           = bus.imem_rsp_valid && (drop_q == '0) && !redir;

  assign bus.if_valid = !q_empty && !redir;
  assign bus.if_pc    = q_dout.pc;
  assign bus.if_inst  = q_dout.inst;

  assign q_din.pc   = pcf_dout;
  assign q_din.inst = bus.imem_rsp_data;

  assign unused_ok = ^{pcf_count, pcf_full, pcf_empty, q_full, bus.redirect_pc[1:0], redir_mis};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    outst_d = outst_q;
    drop_d  = drop_q;

    case (state_q)
      BOOT:    state_d = FETCH;
      default: state_d = state_q;
    endcase

    if (redir) begin
      // Everything still in flight, bar a response landing now, must be discarded.
      pc_d    = {bus.redirect_pc[XLEN-1:2], 2'b00};
      outst_d = outst_q - CW'(bus.imem_rsp_valid);
      drop_d  = outst_q - CW'(bus.imem_rsp_valid);
      state_d = redir_mis ? TRAP : FETCH;
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      outst_d = outst_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
      if (bus.imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // PCs of accepted, not-yet-returned requests, re-paired with their responses in order.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_pc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (req_fire),
    .din   (pc_q),
    .pop   (rsp_keep),
    .dout  (pcf_dout),
    .count (pcf_count),
    .full  (pcf_full),
    .empty (pcf_empty)
  );

  fetch_fifo #(.WIDTH($bits(fq_entry_t)), .DEPTH(BUF_DEPTH)) u_inst_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (rsp_keep),
    .din   (q_din),
    .pop   (if_fire),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order imem model of configurable latency.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(32'h0000_1000), .BUF_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_vec = 0;
  int n_err = 0;
  int cycle = 0;
  int lat   = 1;
  int n_req_fire = 0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];

  logic        s_rv, s_iv, s_mis, s_req_fire, s_if_fire;
  logic [31:0] s_addr, s_pc, s_inst;

  typedef struct {
    bit          if_rdy;
    bit          mem_rdy;
    bit          redir;
    logic [31:0] redir_pc;
    bit          exp_rv;
    logic [31:0] exp_addr;
    bit          exp_iv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[7];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle, act, exp);
    end
  endtask

  // One clock cycle: memory drives its response, outputs are sampled mid-low-phase.
  task automatic cyc();
    if (pend.size() > 0 && pend[0].due <= cycle) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = inst_of(pend[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
    #1;
    s_rv       = bus.imem_req_valid;
    s_addr     = bus.imem_req_addr;
    s_iv       = bus.if_valid;
    s_pc       = bus.if_pc;
    s_inst     = bus.if_inst;
    s_mis      = bus.fetch_misalign;
    s_req_fire = s_rv && bus.imem_req_ready;
    s_if_fire  = s_iv && bus.if_ready;
    if (bus.imem_rsp_valid) void'(pend.pop_front());
    if (s_req_fire) begin
      pend.push_back('{s_addr, cycle + lat});
      n_req_fire++;
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic do_reset(input int l);
    rst_n               = 1'b0;
    bus.imem_req_ready  = 1'b1;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.if_ready        = 1'b1;
    pend.delete();
    lat = l;
    @(negedge clk);
    @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_req_addr",  bus.imem_req_addr,       32'h0000_1000);
    check("rst_if_valid",  32'(bus.if_valid),       32'd0);
    check("rst_if_pc",     bus.if_pc,               32'd0);
    check("rst_if_inst",   bus.if_inst,             32'd0);
    check("rst_misalign",  32'(bus.fetch_misalign), 32'd0);
    rst_n      = 1'b1;
    cycle      = 0;
    n_req_fire = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] first_req, first_if;
    bit          got_req, got_if;

    // Startup from reset, 1-cycle memory, decode always ready.
    vt[0] = '{1, 1, 0, 32'h0, 0, 32'h0000_1000, 0, 32'h0};
    vt[1] = '{1, 1, 0, 32'h0, 1, 32'h0000_1000, 0, 32'h0};
    vt[2] = '{1, 1, 0, 32'h0, 1, 32'h0000_1004, 0, 32'h0};
    vt[3] = '{1, 1, 0, 32'h0, 1, 32'h0000_1008, 1, 32'h0000_1000};
    vt[4] = '{1, 1, 0, 32'h0, 1, 32'h0000_100C, 1, 32'h0000_1004};
    vt[5] = '{1, 1, 0, 32'h0, 1, 32'h0000_1010, 1, 32'h0000_1008};
    vt[6] = '{1, 1, 0, 32'h0, 1, 32'h0000_1014, 1, 32'h0000_100C};

    do_reset(1);
    for (int i = 0; i < 7; i++) begin
      bus.if_ready       = vt[i].if_rdy;
      bus.imem_req_ready = vt[i].mem_rdy;
      bus.redirect_valid = vt[i].redir;
      bus.redirect_pc    = vt[i].redir_pc;
      cyc();
      check($sformatf("v%0d_req_valid", i), 32'(s_rv), 32'(vt[i].exp_rv));
      check($sformatf("v%0d_req_addr", i),  s_addr,    vt[i].exp_addr);
      check($sformatf("v%0d_if_valid", i),  32'(s_iv), 32'(vt[i].exp_iv));
      check($sformatf("v%0d_if_pc", i),     s_pc,      vt[i].exp_pc);
      if (vt[i].exp_iv) check($sformatf("v%0d_if_inst", i), s_inst, inst_of(vt[i].exp_pc));
    end

    // Decode stalled: queue fills with two entries, requests stop, nothing lost.
    do_reset(1);
    bus.if_ready = 1'b0;
    repeat (10) cyc();
    check("stall_req_count", 32'(n_req_fire), 32'd2);
    check("stall_req_valid", 32'(s_rv), 32'd0);
    check("stall_if_valid",  32'(s_iv), 32'd1);
    check("stall_if_pc",     s_pc,      32'h0000_1000);
    bus.if_ready = 1'b1;
    cyc();
    check("release_req_valid", 32'(s_rv), 32'd1);
    check("release_req_addr",  s_addr,    32'h0000_1008);
    check("release_if_pc0",    s_pc,      32'h0000_1000);
    cyc();
    check("release_if_pc1",    s_pc,      32'h0000_1004);
    check("release_if_inst1",  s_inst,    inst_of(32'h0000_1004));

    // Redirect with two responses in flight on a 3-cycle memory.
    do_reset(3);
    repeat (3) cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2000;
    cyc();
    check("rd2_req_valid", 32'(s_rv), 32'd0);
    check("rd2_if_valid",  32'(s_iv), 32'd0);
    bus.redirect_valid = 1'b0;
    got_req = 0;
    got_if  = 0;
    first_req = '0;
    first_if  = '0;
    for (int i = 0; i < 20 && !(got_req && got_if); i++) begin
      cyc();
      if (s_req_fire && !got_req) begin first_req = s_addr; got_req = 1; end
      if (s_if_fire && !got_if)   begin first_if  = s_pc;   got_if  = 1; end
    end
    check("rd2_first_req_seen", 32'(got_req), 32'd1);
    check("rd2_first_req",      first_req,    32'h0000_2000);
    check("rd2_first_if_seen",  32'(got_if),  32'd1);
    check("rd2_first_if_pc",    first_if,     32'h0000_2000);

    // Redirect coinciding with a response and a would-be pop.
    do_reset(1);
    repeat (3) cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2000;
    cyc();
    check("rdr_req_valid", 32'(s_rv),      32'd0);
    check("rdr_if_fire",   32'(s_if_fire), 32'd0);
    bus.redirect_valid = 1'b0;
    cyc();
    check("rdr_next_if_valid",  32'(s_iv), 32'd0);
    check("rdr_next_req_valid", 32'(s_rv), 32'd1);
    check("rdr_next_req_addr",  s_addr,    32'h0000_2000);
    cyc();
    cyc();
    check("rdr_if_valid", 32'(s_iv), 32'd1);
    check("rdr_if_pc",    s_pc,      32'h0000_2000);

    // Misaligned redirect target.
    do_reset(1);
    repeat (4) cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_2002;
    cyc();
    check("mis_redir_req_valid", 32'(s_rv),  32'd0);
    check("mis_redir_misalign",  32'(s_mis), 32'd0);
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      cyc();
      check($sformatf("trap%0d_misalign", i),  32'(s_mis), 32'd1);
      check($sformatf("trap%0d_req_valid", i), 32'(s_rv),  32'd0);
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_3000;
    cyc();
    check("trap_exit_misalign",  32'(s_mis), 32'd1);
    check("trap_exit_req_valid", 32'(s_rv),  32'd0);
    bus.redirect_valid = 1'b0;
    cyc();
    check("resume_misalign",  32'(s_mis), 32'd0);
    check("resume_req_valid", 32'(s_rv),  32'd1);
    check("resume_req_addr",  s_addr,     32'h0000_3000);
`else
    cyc();
    check("mis_req_valid", 32'(s_rv),  32'd1);
    check("mis_req_addr",  s_addr,     32'h0000_2000);
    check("mis_misalign",  32'(s_mis), 32'd0);
    cyc();
    check("mis_req_addr1", s_addr,     32'h0000_2004);
    cyc();
    check("mis_if_pc",     s_pc,       32'h0000_2000);
`endif

    // Memory not ready: request address is held and the PC does not advance.
    do_reset(1);
    bus.imem_req_ready = 1'b0;
    cyc();
    check("hold_boot_req_valid", 32'(s_rv), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("hold%0d_req_valid", i), 32'(s_rv), 32'd1);
      check($sformatf("hold%0d_req_addr", i),  s_addr,    32'h0000_1000);
    end
    bus.imem_req_ready = 1'b1;
    cyc();
    check("hold_release_addr", s_addr, 32'h0000_1000);
    cyc();
    check("hold_next_addr",    s_addr, 32'h0000_1004);
    check("hold_req_count",    32'(n_req_fire), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
